wb_lsu: RTL and testbench
=========================

WB_LSU -- requirements
Module: wb_lsu

Interface
REQ-001 Parameter DATA_W, default 32, bus data width in bits; SHALL be 32 or 64.
REQ-002 Parameter ADDR_W, default 32, byte-address width.
REQ-003 Parameter TIMEOUT, default 16, maximum cycles to wait for ack_i/err_i; 0 disables the timeout.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-high.
REQ-006 req_i  in  1  core request; sampled only in IDLE.
REQ-007 we_i  in  1  1 = store, 0 = load.
REQ-008 size_i  in  2  access size: 00 byte, 01 half, 10 word, 11 dword (dword legal only when DATA_W=64).
REQ-009 signed_i  in  1  sign-extend load result.
REQ-010 addr_i  in  ADDR_W  byte address.
REQ-011 wdata_i  in  DATA_W  store data, right-justified.
REQ-012 busy_o  out  1  high in every state except IDLE.
REQ-013 done_o  out  1  one-cycle completion pulse.
REQ-014 err_o  out  1  valid with done_o; 1 = misaligned, bus error or timeout.
REQ-015 rdata_o  out  DATA_W  load result, right-justified and extended; held until the next load completes.
REQ-016 adr_o  out  ADDR_W  bus address with log2(DATA_W/8) LSBs forced to 0.
REQ-017 dat_o  out  DATA_W  bus write data, steered to byte lanes.
REQ-018 sel_o  out  DATA_W/8  byte-lane select.
REQ-019 we_o, stb_o, cyc_o  out  1 each  bus write enable, strobe and cycle.
REQ-020 dat_i  in  DATA_W; ack_i, err_i  in  1 each  bus read data, ack and error.

Function
REQ-021 States: IDLE, REQ, RELEASE, FAULT.
REQ-022 IDLE with req_i=1: request fields SHALL be latched. The block SHALL then check alignment: addr_i must be a multiple of the access byte count, and size 11 is illegal when DATA_W=32.
REQ-023 Aligned request: the next state SHALL be REQ. On the same edge, stb_o=cyc_o=1, we_o=we_i, adr_o, sel_o and dat_o SHALL be driven.
REQ-024 Misaligned or illegal request: the next state SHALL be FAULT. stb_o SHALL stay 0; no bus cycle is issued.
REQ-025 sel_o: byte 1 lane, half 2 lanes, word 4 lanes, dword all lanes, shifted left by the lane offset addr[log2(DATA_W/8)-1:0]. For a 32-bit bus: byte at offset 3 gives 1000; half at offset 2 gives 1100.
REQ-026 dat_o: wdata_i, left-shifted by 8*offset bits; unused lanes SHALL be 0.
REQ-027 REQ: a cycle counter SHALL increment each cycle and all bus outputs SHALL be held stable.
REQ-028 REQ, ack_i=1 sampled: stb_o=0 and we_o=0 next edge; next state RELEASE. For a load, dat_i SHALL be right-shifted by 8*offset, masked to the access size and zero- or sign-extended per signed_i into rdata_o.
REQ-029 REQ, err_i=1 sampled: stb_o=0; next state RELEASE; sticky error flag set; rdata_o unchanged. If ack_i and err_i are both high, err_i SHALL win.
REQ-030 REQ, counter reaches TIMEOUT (TIMEOUT>0): stb_o=0, error flag set, next state RELEASE.
REQ-031 RELEASE: cyc_o SHALL stay 1 until ack_i=0 and err_i=0 are sampled. Then cyc_o=0, done_o=1 for one cycle, err_o=error flag, next state IDLE.
REQ-032 FAULT: done_o=1 and err_o=1 for one cycle; next state IDLE.
REQ-033 Minimum latency with a single-cycle ack followed by ack low: done_o SHALL assert 3 cycles after the req_i sample edge.
REQ-034 req_i asserted while busy_o=1 SHALL be ignored, not queued.
REQ-035 The error flag SHALL clear on each new accepted request.

Reset
REQ-036 rst_i=1 SHALL immediately force state IDLE and all outputs to 0, including rdata_o, adr_o, dat_o and sel_o.
REQ-037 Reset mid-transaction SHALL drop stb_o and cyc_o asynchronously; no done_o is issued for the aborted access.

Verification
REQ-038 DATA_W=32, load, addr 0x103, size byte, signed_i=1, dat_i=0x80FFFFFF, 1-cycle ack -> sel_o=1000, adr_o=0x100, rdata_o=0xFFFFFF80, err_o=0, done_o 3 cycles after request.
REQ-039 DATA_W=32, store, addr 0x22, size half, wdata_i=0x0000BEEF -> sel_o=1100, dat_o=0xBEEF0000, we_o=1 until ack.
REQ-040 Load, addr 0x102, size word -> FAULT, done_o=1, err_o=1 on the next cycle; stb_o never asserted.
REQ-041 TIMEOUT=16, ack_i held 0 -> stb_o drops after 16 REQ cycles; done_o=1, err_o=1; rdata_o unchanged.
REQ-042 DATA_W=64, load, addr 0x08, size dword, dat_i=0x1122334455667788 -> sel_o=0xFF, rdata_o=0x1122334455667788; the same access with DATA_W=32 -> FAULT.
REQ-043 rst_i pulsed while in REQ -> stb_o=cyc_o=0 without a clock edge; after release, a new request completes normally.

Source files
------------

// File: rtl/wb_lsu.sv
// Load/store unit: turns one core access into a single Wishbone classic cycle,
// steering data onto byte lanes and extending load results.
//
// state   | meaning
// IDLE    | waiting for req_i; request fields latched and checked here
// REQ     | strobe out, waiting for ack_i / err_i / timeout
// RELEASE | strobe dropped, cyc_o held until slave deasserts ack_i/err_i
// FAULT   | misaligned or illegal size; done_o/err_o high for this cycle
module wb_lsu #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  rst_i,
   input  logic                  req_i,
   input  logic                  we_i,
   input  logic [1:0]            size_i,
   input  logic                  signed_i,
   input  logic [ADDR_W-1:0]     addr_i,
   input  logic [DATA_W-1:0]     wdata_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o,
   output logic [DATA_W-1:0]     rdata_o,
   output logic [ADDR_W-1:0]     adr_o,
   output logic [DATA_W-1:0]     dat_o,
   output logic [DATA_W/8-1:0]   sel_o,
   output logic                  we_o,
   output logic                  stb_o,
   output logic                  cyc_o,
   input  logic [DATA_W-1:0]     dat_i,
   input  logic                  ack_i,
   input  logic                  err_i
);

   localparam int NB    = DATA_W / 8;
   localparam int OFF_W = $clog2(NB);
   localparam int CNT_W = $clog2(TIMEOUT + 2);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_REQ     = 2'd1;
   localparam logic [1:0] S_RELEASE = 2'd2;
   localparam logic [1:0] S_FAULT   = 2'd3;

   logic [1:0]        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [OFF_W-1:0]  r_off;
   logic [1:0]        r_size;
   logic              r_signed;
   logic              r_err_flag;
   logic              r_done;
   logic              r_err;
   logic [DATA_W-1:0] r_rdata;
   logic [ADDR_W-1:0] r_adr;
   logic [DATA_W-1:0] r_dat;
   logic [NB-1:0]     r_sel;
   logic              r_we;
   logic              r_stb;
   logic              r_cyc;

   logic [OFF_W-1:0]  w_off;
   logic              w_aligned;
   logic [NB-1:0]     w_sel;
   logic [DATA_W-1:0] w_dat;
   logic [DATA_W-1:0] w_shift;
   logic [DATA_W-1:0] w_lmask;
   logic              w_fill;
   logic [DATA_W-1:0] w_load;

   function automatic logic [NB-1:0] size_lanes(input logic [1:0] sz);
      case (sz)
         2'b00:   return NB'(1);
         2'b01:   return NB'(3);
         2'b10:   return NB'(15);
         default: return {NB{1'b1}};
      endcase
   endfunction

   function automatic logic [DATA_W-1:0] lane_bits(input logic [NB-1:0] lanes);
      logic [DATA_W-1:0] m;
      m = '0;
      for (int i = 0; i < NB; i++) m[8*i +: 8] = {8{lanes[i]}};
      return m;
   endfunction

   assign w_off = addr_i[OFF_W-1:0];

   always_comb begin
      w_aligned = 1'b1;
      case (size_i)
         2'b01:   w_aligned = ~addr_i[0];
         2'b10:   w_aligned = (addr_i[1:0] == 2'b00);
         2'b11:   w_aligned = (DATA_W == 64) && (addr_i[2:0] == 3'b000);
         default: w_aligned = 1'b1;
      endcase
   end

   // store data is masked to the access size so lanes outside sel_o stay zero
   assign w_sel = size_lanes(size_i) << w_off;
   assign w_dat = (wdata_i & lane_bits(size_lanes(size_i))) << {w_off, 3'b000};

   assign w_shift = dat_i >> {r_off, 3'b000};
   assign w_lmask = lane_bits(size_lanes(r_size));

   always_comb begin
      w_fill = 1'b0;
      case (r_size)
         2'b00:   w_fill = r_signed & w_shift[7];
         2'b01:   w_fill = r_signed & w_shift[15];
         2'b10:   w_fill = r_signed & w_shift[31];
         default: w_fill = 1'b0;
      endcase
   end

   assign w_load = (w_shift & w_lmask) | (~w_lmask & {DATA_W{w_fill}});

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_off      <= '0;
         r_size     <= '0;
         r_signed   <= 1'b0;
         r_err_flag <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_rdata    <= '0;
         r_adr      <= '0;
         r_dat      <= '0;
         r_sel      <= '0;
         r_we       <= 1'b0;
         r_stb      <= 1'b0;
         r_cyc      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (req_i) begin
                  r_off      <= w_off;
                  r_size     <= size_i;
                  r_signed   <= signed_i;
                  r_err_flag <= 1'b0;
                  r_cnt      <= '0;
                  if (w_aligned) begin
                     r_state <= S_REQ;
                     r_stb   <= 1'b1;
                     r_cyc   <= 1'b1;
                     r_we    <= we_i;
                     r_adr   <= {addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                     r_sel   <= w_sel;
                     r_dat   <= w_dat;
                  end else begin
                     r_state <= S_FAULT;
                     r_done  <= 1'b1;
                     r_err   <= 1'b1;
                  end
               end
            end
            S_REQ: begin
               // err_i takes priority over ack_i and leaves rdata_o untouched
               if (err_i) begin
                  r_stb      <= 1'b0;
                  r_we       <= 1'b0;
                  r_err_flag <= 1'b1;
                  r_state    <= S_RELEASE;
               end else if (ack_i) begin
                  r_stb   <= 1'b0;
                  r_we    <= 1'b0;
                  r_state <= S_RELEASE;
                  if (!r_we) r_rdata <= w_load;
               end else if (TIMEOUT > 0 && r_cnt == CNT_W'(TIMEOUT - 1)) begin
                  r_stb      <= 1'b0;
                  r_we       <= 1'b0;
                  r_err_flag <= 1'b1;
                  r_state    <= S_RELEASE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_RELEASE: begin
               if (!ack_i && !err_i) begin
                  r_cyc   <= 1'b0;
                  r_done  <= 1'b1;
                  r_err   <= r_err_flag;
                  r_state <= S_IDLE;
               end
            end
            S_FAULT: r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy_o  = (r_state != S_IDLE);
   assign done_o  = r_done;
   assign err_o   = r_err;
   assign rdata_o = r_rdata;
   assign adr_o   = r_adr;
   assign dat_o   = r_dat;
   assign sel_o   = r_sel;
   assign we_o    = r_we;
   assign stb_o   = r_stb;
   assign cyc_o   = r_cyc;

endmodule

// File: tb/tb_wb_lsu.sv
// Directed bench for wb_lsu: one 32-bit and one 64-bit instance, with a
// registered-slave style ack driven by hand from a single initial block.
module tb_wb_lsu;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req3 = 1'b0, req6 = 1'b0;
   logic        we = 1'b0, sgn = 1'b0;
   logic [1:0]  size = 2'b00;
   logic [31:0] addr = '0;
   logic [31:0] wd3 = '0, di3 = '0;
   logic [63:0] wd6 = '0, di6 = '0;
   logic        ack3 = 1'b0, berr3 = 1'b0, ack6 = 1'b0, berr6 = 1'b0;

   logic        busy3, done3, erro3, weo3, stb3, cyc3;
   logic [31:0] rd3, adr3, dat3;
   logic [3:0]  sel3;
   logic        busy6, done6, erro6, weo6, stb6, cyc6;
   logic [63:0] rd6, dat6;
   logic [31:0] adr6;
   logic [7:0]  sel6;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wb_lsu #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(16)) u32 (
      .clk(clk), .rst_i(rst), .req_i(req3), .we_i(we), .size_i(size),
      .signed_i(sgn), .addr_i(addr), .wdata_i(wd3),
      .busy_o(busy3), .done_o(done3), .err_o(erro3), .rdata_o(rd3),
      .adr_o(adr3), .dat_o(dat3), .sel_o(sel3), .we_o(weo3),
      .stb_o(stb3), .cyc_o(cyc3),
      .dat_i(di3), .ack_i(ack3), .err_i(berr3));

   wb_lsu #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(16)) u64 (
      .clk(clk), .rst_i(rst), .req_i(req6), .we_i(we), .size_i(size),
      .signed_i(sgn), .addr_i(addr), .wdata_i(wd6),
      .busy_o(busy6), .done_o(done6), .err_o(erro6), .rdata_o(rd6),
      .adr_o(adr6), .dat_o(dat6), .sel_o(sel6), .we_o(weo6),
      .stb_o(stb6), .cyc_o(cyc6),
      .dat_i(di6), .ack_i(ack6), .err_i(berr6));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One 32-bit access: request, slave answers one cycle after seeing stb,
   // then drops ack. lat = rising edges from the request sample edge to done_o.
   task automatic bus32(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                        input logic w, input logic [31:0] wd, input logic [31:0] bus,
                        input logic av, input logic ev,
                        output logic [3:0] c_sel, output logic [31:0] c_adr,
                        output logic [31:0] c_dat, output logic c_we,
                        output logic c_err, output int lat);
      lat = -1;
      c_err = 1'bx;
      @(negedge clk); addr = a; size = sz; sgn = sg; we = w; wd3 = wd; req3 = 1'b1;
      @(negedge clk); req3 = 1'b0;
      c_sel = sel3; c_adr = adr3; c_dat = dat3; c_we = weo3;
      @(negedge clk); ack3 = av; berr3 = ev; di3 = bus;
      @(negedge clk); ack3 = 1'b0; berr3 = 1'b0; di3 = '0;
      for (int i = 4; i <= 12; i++) begin
         @(negedge clk);
         if (done3) begin
            lat = i - 1;
            c_err = erro3;
            break;
         end
      end
   endtask

   logic [3:0]  c_sel;
   logic [31:0] c_adr, c_dat;
   logic        c_we, c_err;
   int          lat;
   int          n_stb;
   logic        seen, any_done;

   initial begin
      // reset state
      @(negedge clk);
      chk("rst_busy3", busy3, 0);
      chk("rst_stb3", stb3, 0);
      chk("rst_cyc3", cyc3, 0);
      chk("rst_done3", done3, 0);
      chk("rst_rdata3", rd3, 0);
      chk("rst_adr3", adr3, 0);
      chk("rst_sel3", sel3, 0);
      chk("rst_dat3", dat3, 0);
      chk("rst_sel6", sel6, 0);
      chk("rst_rdata6", rd6, 0);
      rst = 1'b0;

      // signed byte load at offset 3
      bus32(32'h103, 2'b00, 1'b1, 1'b0, 32'h0, 32'h80FF_FFFF, 1'b1, 1'b0,
            c_sel, c_adr, c_dat, c_we, c_err, lat);
      chk("ldb_sel", c_sel, 4'b1000);
      chk("ldb_adr", c_adr, 32'h100);
      chk("ldb_we", c_we, 0);
      chk("ldb_err", c_err, 0);
      chk("ldb_lat", lat, 3);
      chk("ldb_rdata", rd3, 32'hFFFF_FF80);

      // half store at offset 2
      bus32(32'h22, 2'b01, 1'b0, 1'b1, 32'h0000_BEEF, 32'h0, 1'b1, 1'b0,
            c_sel, c_adr, c_dat, c_we, c_err, lat);
      chk("sth_sel", c_sel, 4'b1100);
      chk("sth_dat", c_dat, 32'hBEEF_0000);
      chk("sth_adr", c_adr, 32'h20);
      chk("sth_we", c_we, 1);
      chk("sth_err", c_err, 0);
      chk("sth_lat", lat, 3);
      chk("sth_rdata_kept", rd3, 32'hFFFF_FF80);

      // byte store: upper wdata bits must not reach the bus
      bus32(32'h45, 2'b00, 1'b0, 1'b1, 32'h1234_56A5, 32'h0, 1'b1, 1'b0,
            c_sel, c_adr, c_dat, c_we, c_err, lat);
      chk("stb_sel", c_sel, 4'b0010);
      chk("stb_dat", c_dat, 32'h0000_A500);
      chk("stb_adr", c_adr, 32'h44);

      // half loads, unsigned then signed, and a word load
      bus32(32'h12, 2'b01, 1'b0, 1'b0, 32'h0, 32'h8001_0000, 1'b1, 1'b0,
            c_sel, c_adr, c_dat, c_we, c_err, lat);
      chk("ldhu_rdata", rd3, 32'h0000_8001);
      bus32(32'h12, 2'b01, 1'b1, 1'b0, 32'h0, 32'h8001_0000, 1'b1, 1'b0,
            c_sel, c_adr, c_dat, c_we, c_err, lat);
      chk("ldhs_rdata", rd3, 32'hFFFF_8001);
      bus32(32'h10, 2'b10, 1'b0, 1'b0, 32'h0, 32'h1234_5678, 1'b1, 1'b0,
            c_sel, c_adr, c_dat, c_we, c_err, lat);
      chk("ldw_sel", c_sel, 4'b1111);
      chk("ldw_rdata", rd3, 32'h1234_5678);

      // ack and err together: err wins, rdata kept
      bus32(32'h30, 2'b10, 1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b1, 1'b1,
            c_sel, c_adr, c_dat, c_we, c_err, lat);
      chk("berr_err", c_err, 1);
      chk("berr_lat", lat, 3);
      chk("berr_rdata_kept", rd3, 32'h1234_5678);

      // error flag cleared by the next accepted request
      bus32(32'h34, 2'b10, 1'b0, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b1, 1'b0,
            c_sel, c_adr, c_dat, c_we, c_err, lat);
      chk("clr_err", c_err, 0);
      chk("clr_rdata", rd3, 32'hCAFE_F00D);

      // misaligned word load
      @(negedge clk); addr = 32'h102; size = 2'b10; we = 1'b0; sgn = 1'b0; req3 = 1'b1;
      @(negedge clk); req3 = 1'b0;
      chk("mis_done", done3, 1);
      chk("mis_err", erro3, 1);
      chk("mis_stb", stb3, 0);
      chk("mis_cyc", cyc3, 0);
      chk("mis_busy", busy3, 1);
      @(negedge clk);
      chk("mis_done_pulse", done3, 0);
      chk("mis_idle", busy3, 0);

      // dword on a 32-bit bus is illegal
      @(negedge clk); addr = 32'h08; size = 2'b11; req3 = 1'b1;
      @(negedge clk); req3 = 1'b0;
      chk("dw32_done", done3, 1);
      chk("dw32_err", erro3, 1);
      chk("dw32_stb", stb3, 0);

      // request while busy is ignored and not queued
      @(negedge clk); addr = 32'h50; size = 2'b10; req3 = 1'b1;
      @(negedge clk); addr = 32'h60;
      @(negedge clk);
      chk("busy_adr_held", adr3, 32'h50);
      req3 = 1'b0; ack3 = 1'b1; di3 = 32'h1111_2222;
      @(negedge clk); ack3 = 1'b0; di3 = '0;
      @(negedge clk);
      chk("busy_done", done3, 1);
      chk("busy_rdata", rd3, 32'h1111_2222);
      @(negedge clk);
      chk("busy_not_queued", busy3, 0);
      chk("busy_no_stb", stb3, 0);

      // timeout: no ack at all
      @(negedge clk); addr = 32'h104; size = 2'b10; req3 = 1'b1;
      n_stb = 0; seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         req3 = 1'b0;
         if (stb3) n_stb++;
         if (done3) begin
            seen = 1'b1;
            chk("to_err", erro3, 1);
            break;
         end
      end
      chk("to_done_seen", seen, 1);
      chk("to_stb_cycles", n_stb, 16);
      chk("to_rdata_kept", rd3, 32'h1111_2222);

      // asynchronous reset in the middle of REQ
      @(negedge clk); addr = 32'h70; size = 2'b10; req3 = 1'b1;
      @(negedge clk); req3 = 1'b0;
      chk("arst_pre_stb", stb3, 1);
      #1 rst = 1'b1;
      #1;
      chk("arst_stb", stb3, 0);
      chk("arst_cyc", cyc3, 0);
      chk("arst_busy", busy3, 0);
      chk("arst_rdata", rd3, 0);
      @(negedge clk); rst = 1'b0;
      any_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (done3) any_done = 1'b1;
      end
      chk("arst_no_done", any_done, 0);
      bus32(32'h74, 2'b10, 1'b0, 1'b0, 32'h0, 32'h0BAD_F00D, 1'b1, 1'b0,
            c_sel, c_adr, c_dat, c_we, c_err, lat);
      chk("arst_after_err", c_err, 0);
      chk("arst_after_lat", lat, 3);
      chk("arst_after_rdata", rd3, 32'h0BAD_F00D);

      // 64-bit bus: dword load
      @(negedge clk); addr = 32'h08; size = 2'b11; sgn = 1'b0; we = 1'b0; req6 = 1'b1;
      @(negedge clk); req6 = 1'b0;
      chk("dw_sel", sel6, 8'hFF);
      chk("dw_adr", adr6, 32'h08);
      chk("dw_stb", stb6, 1);
      @(negedge clk); ack6 = 1'b1; di6 = 64'h1122_3344_5566_7788;
      @(negedge clk); ack6 = 1'b0; di6 = '0;
      @(negedge clk);
      chk("dw_done", done6, 1);
      chk("dw_err", erro6, 0);
      chk("dw_rdata", rd6, 64'h1122_3344_5566_7788);

      // 64-bit byte store at offset 5
      @(negedge clk); addr = 32'h0D; size = 2'b00; we = 1'b1;
      wd6 = 64'hFFFF_FFFF_FFFF_FFA5; req6 = 1'b1;
      @(negedge clk); req6 = 1'b0;
      chk("st64_sel", sel6, 8'h20);
      chk("st64_dat", dat6, 64'h0000_A500_0000_0000);
      chk("st64_adr", adr6, 32'h08);
      chk("st64_we", weo6, 1);
      @(negedge clk); ack6 = 1'b1;
      @(negedge clk); ack6 = 1'b0;
      @(negedge clk);
      chk("st64_done", done6, 1);

      // 64-bit signed word load at offset 4
      @(negedge clk); addr = 32'h1C; size = 2'b10; we = 1'b0; sgn = 1'b1; req6 = 1'b1;
      @(negedge clk); req6 = 1'b0;
      chk("lw64_sel", sel6, 8'hF0);
      chk("lw64_adr", adr6, 32'h18);
      @(negedge clk); ack6 = 1'b1; di6 = 64'h8000_0000_0000_0000;
      @(negedge clk); ack6 = 1'b0; di6 = '0;
      @(negedge clk);
      chk("lw64_done", done6, 1);
      chk("lw64_rdata", rd6, 64'hFFFF_FFFF_8000_0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed no end of stimulus expected finish");
      $fatal(1, "watchdog");
   end

endmodule
